// File: rtl/rep_seq_if.sv
// rep_seq_if: trigger/event inputs and result/statistics outputs of rep_seq_checker
interface rep_seq_if #(parameter int CNT_W = 16);
  logic a, b, c;
  logic busy, pass, fail, abort;
  logic [1:0] fail_code;
  logic [CNT_W-1:0] pass_cnt, fail_cnt, ign_cnt;
  modport master (output a, b, c, input busy, pass, fail, fail_code, abort, pass_cnt, fail_cnt, ign_cnt);
  modport slave (input a, b, c, output busy, pass, fail, fail_code, abort, pass_cnt, fail_cnt, ign_cnt);
endinterface

// File: rtl/rep_seq_checker.sv
// rep_seq_checker: monitors "rise(a) |-> b[=REP_COUNT] ##1 c" with timeout; define REP_SEQ_RESTART_EN to restart on a retrigger
module rep_seq_checker #(
  parameter int REP_COUNT = 3,
  parameter int MAX_WAIT = 64,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  rep_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, COUNT, WAIT_C} state_t;
  localparam logic [3:0] REP = 4'(REP_COUNT);
  localparam logic [15:0] MAXW = 16'(MAX_WAIT);
  state_t state, state_n;
  logic a_q, rise, restart, pass_n, fail_n, abort_n, ign_n;
  logic [1:0] code_n;
  logic [3:0] bcnt, bcnt_n, bcnt_b;
  logic [15:0] wcnt, wcnt_n;
  assign rise = bus.a & ~a_q;
  assign bus.busy = state != IDLE;
`ifdef REP_SEQ_RESTART_EN
  assign restart = rise & (state != IDLE);
`else
  assign restart = 1'b0;
`endif
  assign bcnt_b = bcnt + 4'(bus.b);
  always_comb begin
    state_n = state;
    bcnt_n = bcnt;
    wcnt_n = wcnt;
    pass_n = 1'b0;
    fail_n = 1'b0;
    abort_n = 1'b0;
    ign_n = 1'b0;
    code_n = 2'd0;
    if (state == IDLE || restart) begin
      if (rise) begin
        bcnt_n = 4'(bus.b);
        wcnt_n = 16'd1;
        state_n = (bus.b && REP == 4'd1) ? WAIT_C : COUNT;
        abort_n = restart;
      end
    end else begin
      ign_n = rise;
      wcnt_n = wcnt + 16'd1;
      // a b coinciding with c lies outside the b[=N] window, so c wins
      if (state == WAIT_C && bus.c) begin
        pass_n = 1'b1;
        state_n = IDLE;
      end else if (state == WAIT_C && bus.b) begin
        fail_n = 1'b1;
        code_n = 2'd1;
        state_n = IDLE;
      end else if (wcnt == MAXW) begin
        fail_n = 1'b1;
        code_n = 2'd2;
        state_n = IDLE;
      end else if (state == COUNT) begin
        bcnt_n = bcnt_b;
        state_n = (bcnt_b == REP) ? WAIT_C : COUNT;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      a_q <= 1'b0;
      bcnt <= '0;
      wcnt <= '0;
      bus.pass <= 1'b0;
      bus.fail <= 1'b0;
      bus.abort <= 1'b0;
      bus.fail_code <= 2'd0;
      bus.pass_cnt <= '0;
      bus.fail_cnt <= '0;
      bus.ign_cnt <= '0;
    end else begin
      state <= state_n;
      a_q <= bus.a;
      bcnt <= bcnt_n;
      wcnt <= wcnt_n;
      bus.pass <= pass_n;
      bus.fail <= fail_n;
      bus.abort <= abort_n;
      if (fail_n) bus.fail_code <= code_n;
      if (pass_n && !(&bus.pass_cnt)) bus.pass_cnt <= bus.pass_cnt + CNT_W'(1);
      if (fail_n && !(&bus.fail_cnt)) bus.fail_cnt <= bus.fail_cnt + CNT_W'(1);
      if (ign_n && !(&bus.ign_cnt)) bus.ign_cnt <= bus.ign_cnt + CNT_W'(1);
    end
endmodule
